// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and writeback for the 32-bit core.
// Optional MULTICYCLE_MEM_READY_EN adds a mem_ready input that stalls FETCH, MEMRD and MEMWR.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef MULTICYCLE_MEM_READY_EN
  input  logic       mem_ready,
`endif
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       signext,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] IMMEX   = 4'd9;
  localparam logic [3:0] IMMWB   = 4'd10;
  localparam logic [3:0] JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] next_state;
  logic       stall;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       imm_sext;
  logic [2:0] imm_alu;

`ifdef MULTICYCLE_MEM_READY_EN
  assign stall = ~mem_ready;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Logical immediates zero-extend; arithmetic ones sign-extend.
  always_comb begin
    imm_sext = 1'b1;
    imm_alu  = ALU_ADD;
    case (op)
      OP_SLTI: imm_alu = ALU_SLT;
      OP_ANDI: begin imm_sext = 1'b0; imm_alu = ALU_AND; end
      OP_ORI:  begin imm_sext = 1'b0; imm_alu = ALU_OR;  end
      default: imm_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    pc_en      = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    signext    = 1'b1;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        irwrite    = 1'b1;
        pc_en      = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        next_state = stall ? FETCH : DECODE;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW:                     next_state = MEMADR;
          OP_RTYPE:                         next_state = RTYPEEX;
          OP_BEQ, OP_BNE:                   next_state = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = IMMEX;
          OP_J:                             next_state = JUMP;
          default: begin
            illegal    = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        next_state = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord       = 1'b1;
        next_state = stall ? MEMRD : MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        next_state = stall ? MEMWR : FETCH;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        if (funct_ok) next_state = RTYPEWB;
        else          illegal    = 1'b1;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pc_en      = (op == OP_BNE) ? ~zero : zero;
      end
      IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        signext    = imm_sext;
        alucontrol = imm_alu;
        next_state = IMMWB;
      end
      IMMWB: begin
        regwrite   = 1'b1;
        signext    = imm_sext;
        alucontrol = imm_alu;
      end
      JUMP: begin
        pcsrc = 2'b10;
        pc_en = 1'b1;
      end
      default: next_state = FETCH;
    endcase
    // Reset cycle must never write anything, whatever state we were in.
    if (reset) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      signext    = 1'b1;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= next_state;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instructions checked cycle by cycle
// against an instruction-level model of the expected control outputs.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [16:0] M_PCEN = 17'h10000;
  localparam logic [16:0] M_IORD = 17'h08000;
  localparam logic [16:0] M_MW   = 17'h04000;
  localparam logic [16:0] M_IW   = 17'h02000;
  localparam logic [16:0] M_RD   = 17'h01000;
  localparam logic [16:0] M_MR   = 17'h00800;
  localparam logic [16:0] M_RW   = 17'h00400;
  localparam logic [16:0] M_SA   = 17'h00200;
  localparam logic [16:0] M_SB   = 17'h00180;
  localparam logic [16:0] M_PS   = 17'h00060;
  localparam logic [16:0] M_AC   = 17'h0001c;
  localparam logic [16:0] M_SX   = 17'h00002;
  localparam logic [16:0] M_IL   = 17'h00001;
  localparam logic [16:0] M_EN   = M_PCEN | M_MW | M_IW | M_RW | M_IL;

  typedef struct packed {
    logic [16:0] val;
    logic [16:0] msk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       signext, illegal;
  logic [3:0] state;
`ifdef MULTICYCLE_MEM_READY_EN
  logic       mem_ready;
`endif

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [16:0] obsVec;
  assign obsVec = {pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                   alusrca, alusrcb, pcsrc, alucontrol, signext, illegal};

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk),
    .reset(reset),
`ifdef MULTICYCLE_MEM_READY_EN
    .mem_ready(mem_ready),
`endif
    .op(op),
    .funct(funct),
    .zero(zero),
    .pc_en(pc_en),
    .iord(iord),
    .memwrite(memwrite),
    .irwrite(irwrite),
    .regdst(regdst),
    .memtoreg(memtoreg),
    .regwrite(regwrite),
    .alusrca(alusrca),
    .alusrcb(alusrcb),
    .pcsrc(pcsrc),
    .alucontrol(alucontrol),
    .signext(signext),
    .illegal(illegal),
    .state(state)
  );

  function automatic logic knownOp(input logic [5:0] o);
    return o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
                     OP_ANDI, OP_ORI, OP_SLTI, OP_J};
  endfunction

  function automatic logic functOk(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] functAlu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] immAlu(input logic [5:0] o);
    case (o)
      OP_ANDI: return 3'b000;
      OP_ORI:  return 3'b001;
      OP_SLTI: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Cycles per instruction including FETCH.
  function automatic int latencyOf(input logic [5:0] o, input logic [5:0] f);
    if (!knownOp(o))                   return 2;
    if (o == OP_LW)                    return 5;
    if (o == OP_RTYPE && !functOk(f))  return 3;
    if (o inside {OP_BEQ, OP_BNE, OP_J}) return 3;
    return 4;
  endfunction

  // Expected control word for cycle k of an instruction; mask marks the fields that matter.
  function automatic exp_t expectCycle(input logic [5:0] o, input logic [5:0] f,
                                       input logic z, input int k);
    logic pe, io, mw, iw, rd, mr, rw, sa, sx, il;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    logic [16:0] care;
    exp_t e;
    {pe, io, mw, iw, rd, mr, rw, sa, sx, il} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b000;
    care = M_EN;
    if (k == 0) begin
      iw = 1'b1; pe = 1'b1; sb = 2'b01; ac = 3'b010;
      care |= M_IORD | M_SA | M_SB | M_AC | M_PS;
    end else if (k == 1) begin
      sb = 2'b11; ac = 3'b010; sx = 1'b1; il = !knownOp(o);
      care |= M_SA | M_SB | M_AC | M_SX;
    end else if (o == OP_LW || o == OP_SW) begin
      if (k == 2) begin
        sa = 1'b1; sb = 2'b10; ac = 3'b010; sx = 1'b1;
        care |= M_SA | M_SB | M_AC | M_SX;
      end else if (k == 3) begin
        io = 1'b1; mw = (o == OP_SW);
        care |= M_IORD;
      end else begin
        mr = 1'b1; rw = 1'b1;
        care |= M_RD | M_MR;
      end
    end else if (o == OP_RTYPE) begin
      if (k == 2) begin
        if (functOk(f)) begin
          sa = 1'b1; sb = 2'b00; ac = functAlu(f);
          care |= M_SA | M_SB | M_AC;
        end else il = 1'b1;
      end else begin
        rd = 1'b1; rw = 1'b1;
        care |= M_RD | M_MR;
      end
    end else if (o == OP_BEQ || o == OP_BNE) begin
      sa = 1'b1; sb = 2'b00; ac = 3'b110; ps = 2'b01;
      pe = (o == OP_BEQ) ? z : !z;
      care |= M_SA | M_SB | M_AC | M_PS;
    end else if (o == OP_J) begin
      ps = 2'b10; pe = 1'b1;
      care |= M_PS;
    end else begin
      sx = !(o == OP_ANDI || o == OP_ORI);
      ac = immAlu(o);
      if (k == 2) begin
        sa = 1'b1; sb = 2'b10;
        care |= M_SA | M_SB | M_SX | M_AC;
      end else begin
        rw = 1'b1;
        care |= M_RD | M_MR | M_SX | M_AC;
      end
    end
    e.val = {pe, io, mw, iw, rd, mr, rw, sa, sb, ps, ac, sx, il};
    e.msk = care;
    return e;
  endfunction

  function automatic logic [5:0] randomOp();
    logic [5:0] legal [10] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J};
    logic [5:0] cand;
    if ($urandom_range(0, 99) >= 15) return legal[$urandom_range(0, 9)];
    for (int t = 0; t < 16; t++) begin
      cand = 6'($urandom_range(0, 63));
      if (!knownOp(cand)) return cand;
    end
    return 6'b111111;
  endfunction

  function automatic logic [5:0] randomFunct();
    logic [5:0] legal [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    if ($urandom_range(0, 99) < 80) return legal[$urandom_range(0, 4)];
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z);
    op    = o;
    funct = f;
    zero  = z;
  endtask

  task automatic checkOutput(input string tag, input logic [16:0] got,
                             input logic [16:0] expv, input logic [16:0] msk);
    checkCount++;
    assert ((got & msk) === (expv & msk)) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: got %h expected %h mask %h", tag, got & msk, expv & msk, msk);
    end
  endtask

  task automatic cycleCheck(input logic [5:0] o, input logic [5:0] f, input logic z, input int k);
    exp_t e;
    @(negedge clk);
    e = expectCycle(o, f, z, k);
    checkOutput($sformatf("ctl op=%b funct=%b zero=%b k=%0d", o, f, z, k), obsVec, e.val, e.msk);
    if (k == 0) checkOutput("state_fetch", {13'd0, state}, 17'd0, 17'h0000f);
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic z);
    int lat;
    lat = latencyOf(o, f);
    applyStimulus(o, f, z);
    for (int k = 0; k < lat; k++) cycleCheck(o, f, z, k);
  endtask

  initial begin
    reset = 1'b1;
`ifdef MULTICYCLE_MEM_READY_EN
    mem_ready = 1'b1;
`endif
    applyStimulus(6'd0, 6'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", obsVec, M_SX, 17'h1ffff);
    checkOutput("reset_state", {13'd0, state}, 17'd0, 17'h0000f);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset while lw sits in MEMRD: the load must be abandoned without a register write.
    applyStimulus(OP_LW, 6'd0, 1'b0);
    for (int k = 0; k < 3; k++) cycleCheck(OP_LW, 6'd0, 1'b0, k);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_memrd", obsVec, M_SX, 17'h1ffff);
    @(posedge clk);
    #1;
    reset = 1'b0;

    runInstr(OP_LW,    6'd0,      1'b0);
    runInstr(OP_RTYPE, 6'b100010, 1'b0);
    runInstr(OP_BEQ,   6'd0,      1'b1);
    runInstr(OP_BNE,   6'd0,      1'b1);
    runInstr(OP_ANDI,  6'd0,      1'b0);
    runInstr(OP_ADDI,  6'd0,      1'b0);
    runInstr(6'b111111, 6'd0,     1'b0);
    runInstr(OP_SW,    6'd0,      1'b0);
    runInstr(OP_J,     6'd0,      1'b0);
    runInstr(OP_ORI,   6'd0,      1'b0);
    runInstr(OP_SLTI,  6'd0,      1'b0);
    runInstr(OP_BEQ,   6'd0,      1'b0);
    runInstr(OP_BNE,   6'd0,      1'b0);
    runInstr(OP_RTYPE, 6'b111111, 1'b0);
    runInstr(OP_RTYPE, 6'b101010, 1'b1);

`ifdef MULTICYCLE_MEM_READY_EN
    // Memory not ready for three cycles: FETCH holds with its enables still high.
    mem_ready = 1'b0;
    applyStimulus(OP_J, 6'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_fetch_ctl", obsVec, M_PCEN | M_IW, M_EN);
      checkOutput("stall_fetch_state", {13'd0, state}, 17'd0, 17'h0000f);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    runInstr(OP_J, 6'd0, 1'b0);
`endif

    for (int n = 0; n < 200; n++) begin
      logic [5:0] ro, rf;
      logic rz;
      ro = randomOp();
      rf = randomFunct();
      rz = 1'($urandom_range(0, 1));
      runInstr(ro, rf, rz);
    end

    @(negedge clk);
    checkOutput("final_state", {13'd0, state}, 17'd0, 17'h0000f);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
